// File: rtl/mem_stage_pipelined.sv
// MIPS MEM stage: byte/half/word loads and stores over a multi-cycle data
// memory, with the MEM/WB register folded in and EX stalled via in_ready.
module mem_stage_pipelined #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned REG_W       = 10,
  parameter int unsigned CTRL_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   Mem_Addr,
  input  logic [DATA_W-1:0]   Mem_Data,
  input  logic [REG_W-1:0]    RegMem,
  input  logic [CTRL_W+4:0]   control_signals_MEM,
  output logic                out_valid,
  output logic [DATA_W-1:0]   Mem_Read_Data,
  output logic [DATA_W-1:0]   Reg_File_Data,
  output logic [CTRL_W-1:0]   control_signals,
  output logic [REG_W-1:0]    RegWB,
  output logic                misaligned,
  output logic [DATA_W-1:0]   MemoryForwarded
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned RD_B  = CTRL_W + 4;
  localparam int unsigned WR_B  = CTRL_W + 3;
  localparam int unsigned UNS_B = CTRL_W;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  reg_mem;
    logic [CTRL_W+4:0] ctrl;
  } op_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  op_t               in_op, held_op, cur_op;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle_c, accept_c, in_is_mem_c, fast_c, slow_c, done_c, complete_c;
  logic              rd_c, wr_c, uns_c, is_mem_c, mis_c, store_en_c;
  logic [1:0]        size_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rword_c, store_word_c, load_c;
  logic [7:0]        lb_c;
  logic [15:0]       lh_c;

  assign MemoryForwarded = Mem_Addr;
  assign idle_c          = (state == IDLE);
  assign in_ready        = idle_c;
  assign accept_c        = in_valid && idle_c;

  assign in_op = '{addr: Mem_Addr, data: Mem_Data, reg_mem: RegMem, ctrl: control_signals_MEM};
  assign in_is_mem_c = control_signals_MEM[RD_B] || control_signals_MEM[WR_B];

  // Single-edge completion for non-memory ops or when the memory is 1-cycle.
  assign fast_c     = accept_c && (!in_is_mem_c || (MEM_LATENCY == 1));
  assign slow_c     = accept_c && in_is_mem_c && (MEM_LATENCY > 1);
  assign done_c     = (state == BUSY) && (cnt == CNT_W'(1));
  assign complete_c = fast_c || done_c;
  assign cur_op     = (state == BUSY) ? held_op : in_op;

  assign rd_c     = cur_op.ctrl[RD_B];
  assign wr_c     = cur_op.ctrl[WR_B];
  assign size_c   = cur_op.ctrl[CTRL_W+2:CTRL_W+1];
  assign uns_c    = cur_op.ctrl[UNS_B];
  assign is_mem_c = rd_c || wr_c;
  assign idx_c    = cur_op.addr[IDX_W+1:2];
  assign rword_c  = mem[idx_c];

  // Size 2'b11 is handled as a word access.
  assign mis_c = is_mem_c &&
                 (((size_c == 2'b01) && cur_op.addr[0]) ||
                  (size_c[1] && (cur_op.addr[1:0] != 2'b00)));

  assign store_en_c = complete_c && wr_c && !mis_c && reset;

  always_comb begin
    store_word_c = rword_c;
    case (size_c)
      2'b00:   store_word_c[{cur_op.addr[1:0], 3'b000} +: 8]  = cur_op.data[7:0];
      2'b01:   store_word_c[{cur_op.addr[1], 4'b0000} +: 16] = cur_op.data[15:0];
      default: store_word_c = cur_op.data;
    endcase
  end

  // Little-endian lane extraction and extension.
  always_comb begin
    lb_c   = 8'(rword_c >> {cur_op.addr[1:0], 3'b000});
    lh_c   = 16'(rword_c >> {cur_op.addr[1], 4'b0000});
    load_c = '0;
    if (rd_c && !wr_c && !mis_c) begin
      case (size_c)
        2'b00:   load_c = uns_c ? DATA_W'(lb_c) : {{(DATA_W-8){lb_c[7]}}, lb_c};
        2'b01:   load_c = uns_c ? DATA_W'(lh_c) : {{(DATA_W-16){lh_c[15]}}, lh_c};
        default: load_c = rword_c;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store_en_c) mem[idx_c] <= store_word_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (slow_c) state_nxt = BUSY;
      BUSY:    if (done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter and in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      held_op <= '0;
    end else if (slow_c) begin
      cnt     <= CNT_W'(MEM_LATENCY - 1);
      held_op <= in_op;
    end else if (state == BUSY) begin
      cnt     <= cnt - CNT_W'(1);
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      Mem_Read_Data   <= '0;
      Reg_File_Data   <= '0;
      control_signals <= '0;
      RegWB           <= '0;
      misaligned      <= 1'b0;
    end else begin
      out_valid <= complete_c;
      if (complete_c) begin
        Mem_Read_Data   <= load_c;
        Reg_File_Data   <= cur_op.addr;
        control_signals <= cur_op.ctrl[CTRL_W-1:0];
        RegWB           <= cur_op.reg_mem;
        misaligned      <= mis_c;
      end
    end
  end

endmodule
